// File: rtl/ad7124_pkg.sv
// Shared definitions for the AD7124 configuration sequencer.
// Contents: sequencer/shift-engine state enums, table entry payload,
// command prefixes, register address constants, frame helper functions.
package ad7124_pkg;

  localparam int unsigned FRAME_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WR_XFER,
    ST_GAP,
    ST_RD_XFER,
    ST_CHECK,
    ST_GAP2,
    ST_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_LEAD,
    SH_SHIFT,
    SH_TAIL
  } shift_state_t;

  typedef struct packed {
    logic [5:0]  addr;
    logic [23:0] data;
    logic [1:0]  len;
  } tbl_entry_t;

  localparam logic [1:0] AD7124_WR_CMD = 2'b00;
  localparam logic [1:0] AD7124_RD_CMD = 2'b01;

  localparam logic [5:0] ADC_CONTROL  = 6'h01;
  localparam logic [5:0] IO_CONTROL_1 = 6'h03;
  localparam logic [5:0] CHANNEL_0    = 6'h09;
  localparam logic [5:0] CONFIG_0     = 6'h19;
  localparam logic [5:0] FILTER_0     = 6'h21;

  // Mask selecting the low len bytes of right-justified data.
  function automatic logic [23:0] data_mask(input logic [1:0] len);
    case (len)
      2'd1:    return 24'h0000FF;
      2'd2:    return 24'h00FFFF;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  // Total frame length in bits: command byte plus len data bytes.
  function automatic logic [5:0] frame_bits(input logic [1:0] len);
    case (len)
      2'd1:    return 6'd16;
      2'd2:    return 6'd24;
      2'd3:    return 6'd32;
      default: return 6'd8;
    endcase
  endfunction

  // MSB-aligned 32-bit frame: command byte then the len data bytes.
  function automatic logic [31:0] build_frame(input logic [1:0] cmd, input logic [5:0] addr,
                                              input logic [23:0] data, input logic [1:0] len);
    logic [23:0] d;
    d = data & data_mask(len);
    case (len)
      2'd1:    return {cmd, addr, d[7:0], 16'h0000};
      2'd2:    return {cmd, addr, d[15:0], 8'h00};
      default: return {cmd, addr, d};
    endcase
  endfunction

endpackage

// File: rtl/ad7124_spi_shift.sv
// SPI mode 3 shift engine shared by write and readback transfers.
// Ports: PL_clk/rst; go (accepted when ready), frame (MSB-aligned), nbits,
// cs_mask (one-hot line to assert, may be zero); ready, rdata (bits shifted
// in, last bit at LSB); spi_sclk/spi_cs_n/spi_mosi out, spi_miso in.
module ad7124_spi_shift
  import ad7124_pkg::*;
#(
  parameter int unsigned DIV    = 8,
  parameter int unsigned NUM_CS = 7
) (
  input  logic              PL_clk,
  input  logic              rst,
  input  logic              go,
  input  logic [31:0]       frame,
  input  logic [5:0]        nbits,
  input  logic [NUM_CS-1:0] cs_mask,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              spi_sclk,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  shift_state_t      st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        half_q, half_d;
  logic [31:0]       tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic [5:0]        nbits_q, nbits_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              ready_q, ready_d;
  logic              tick;
  logic [6:0]        last_half;

  // State and datapath registers; bus idles with sclk high, cs_n high.
  always_ff @(posedge PL_clk or posedge rst) begin
    if (rst) begin
      st_q    <= SH_IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      nbits_q <= '0;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
      ready_q <= 1'b1;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      nbits_q <= nbits_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      ready_q <= ready_d;
    end
  end

  // Next-state: lead-in, 2*nbits half periods, then a trailing high guard.
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    nbits_d   = nbits_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    tick      = (cnt_q == CNT_LAST);
    last_half = 7'({nbits_q, 1'b0}) - 7'd1;

    case (st_q)
      SH_IDLE: begin
        if (go) begin
          st_d    = SH_LEAD;
          cnt_d   = '0;
          half_d  = '0;
          tx_d    = frame;
          rx_d    = '0;
          nbits_d = nbits;
          cs_n_d  = ~cs_mask;
        end
      end
      SH_LEAD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          mosi_d = tx_q[31];
          tx_d   = tx_q << 1;
          st_d   = SH_SHIFT;
        end
      end
      SH_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
          cnt_d  = '0;
          half_d = half_q + 7'd1;
          if (!half_q[0]) begin
            // Rising edge: capture MISO.
            sclk_d = 1'b1;
            rx_d   = {rx_q[30:0], spi_miso};
          end else if (half_q == last_half) begin
            st_d = SH_TAIL;
          end else begin
            // Falling edge: present next bit.
            sclk_d = 1'b0;
            mosi_d = tx_q[31];
            tx_d   = tx_q << 1;
          end
        end
      end
      SH_TAIL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
          cnt_d  = '0;
          cs_n_d = '1;
          mosi_d = 1'b0;
          st_d   = SH_IDLE;
        end
      end
      default: st_d = SH_IDLE;
    endcase

    ready_d = (st_d == SH_IDLE);
  end

  assign ready    = ready_q;
  assign rdata    = rx_q;
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: rtl/ad7124_cfg_seq.sv
// Table-driven AD7124 register-write sequencer with optional readback verify.
// Ports: PL_clk/rst; start, chip_sel, verify_en (sampled at start);
// tbl_idx out / tbl_addr, tbl_data, tbl_len in (combinational table);
// busy, done, err, err_idx status; spi_sclk, spi_cs_n, spi_mosi, spi_miso.
module ad7124_cfg_seq
  import ad7124_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 6,
  parameter int unsigned DIV        = 8,
  parameter int unsigned GAP_CYCLES = 800,
  parameter int unsigned NUM_CS     = 7,
  localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              PL_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        chip_sel,
  input  logic              verify_en,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [5:0]        tbl_addr,
  input  logic [23:0]       tbl_data,
  input  logic [1:0]        tbl_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  err_idx,
  output logic              spi_sclk,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  tbl_entry_t        entry_q, entry_d;
  logic [2:0]        cs_sel_q, cs_sel_d;
  logic              verify_q, verify_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  err_idx_q, err_idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              launched_q, launched_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              shift_go;
  logic              shift_ready;
  logic [31:0]       shift_frame;
  logic [5:0]        shift_nbits;
  logic [31:0]       shift_rdata;
  logic [NUM_CS-1:0] cs_mask;
  logic              is_read;
  logic              mismatch;

  // Out-of-range chip_sel runs the sequence with no line selected.
  assign cs_mask = (32'(cs_sel_q) < NUM_CS) ? (NUM_CS'(1) << cs_sel_q) : '0;

  assign is_read     = (state_q == ST_RD_XFER);
  assign shift_frame = build_frame(is_read ? AD7124_RD_CMD : AD7124_WR_CMD, entry_q.addr,
                                   is_read ? 24'h000000 : entry_q.data, entry_q.len);
  assign shift_nbits = frame_bits(entry_q.len);
  assign mismatch    = ((shift_rdata & {8'h00, data_mask(entry_q.len)}) !=
                        {8'h00, entry_q.data & data_mask(entry_q.len)});

  ad7124_spi_shift #(
    .DIV    (DIV),
    .NUM_CS (NUM_CS)
  ) u_shift (
    .PL_clk   (PL_clk),
    .rst      (rst),
    .go       (shift_go),
    .frame    (shift_frame),
    .nbits    (shift_nbits),
    .cs_mask  (cs_mask),
    .ready    (shift_ready),
    .rdata    (shift_rdata),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  // State and sequencer registers.
  always_ff @(posedge PL_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      entry_q    <= '0;
      cs_sel_q   <= '0;
      verify_q   <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      gap_q      <= '0;
      launched_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      entry_q    <= entry_d;
      cs_sel_q   <= cs_sel_d;
      verify_q   <= verify_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      gap_q      <= gap_d;
      launched_q <= launched_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and sequencing control.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    entry_d    = entry_q;
    cs_sel_d   = cs_sel_q;
    verify_d   = verify_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    gap_d      = gap_q;
    launched_d = launched_q;
    shift_go   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cs_sel_d  = chip_sel;
          verify_d  = verify_en;
          err_d     = 1'b0;
          err_idx_d = '0;
          idx_d     = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        entry_d    = '{addr: tbl_addr, data: tbl_data, len: tbl_len};
        launched_d = 1'b0;
        state_d    = (tbl_len == 2'd0) ? ST_DONE : ST_WR_XFER;
      end
      ST_WR_XFER, ST_RD_XFER: begin
        // Launch once, then wait for the engine to return to idle.
        if (!launched_q) begin
          shift_go   = shift_ready;
          launched_d = shift_ready;
        end else if (shift_ready) begin
          launched_d = 1'b0;
          gap_d      = '0;
          state_d    = is_read ? ST_CHECK : ST_GAP;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_d = 1'b1;
          if (!err_q) err_idx_d = idx_q;
        end
        gap_d   = '0;
        state_d = ST_GAP2;
      end
      ST_GAP, ST_GAP2: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (state_q == ST_GAP && verify_q) begin
            launched_d = 1'b0;
            state_d    = ST_RD_XFER;
          end else if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  assign tbl_idx = idx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_ad7124_cfg_seq.sv
module tb_ad7124_cfg_seq;

  localparam int NUM_REGS = 6;
  localparam int DIV      = 2;
  localparam int GAP      = 4;
  localparam int NUM_CS   = 7;

  logic        PL_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  chip_sel = 3'd0;
  logic        verify_en = 1'b0;
  logic [2:0]  tbl_idx;
  logic [5:0]  tbl_addr;
  logic [23:0] tbl_data;
  logic [1:0]  tbl_len;
  logic        busy, done, err;
  logic [2:0]  err_idx;
  logic        spi_sclk;
  logic [6:0]  spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  always #5 PL_clk = ~PL_clk;

  ad7124_cfg_seq #(
    .NUM_REGS   (NUM_REGS),
    .DIV        (DIV),
    .GAP_CYCLES (GAP),
    .NUM_CS     (NUM_CS)
  ) dut (
    .PL_clk    (PL_clk),
    .rst       (rst),
    .start     (start),
    .chip_sel  (chip_sel),
    .verify_en (verify_en),
    .tbl_idx   (tbl_idx),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .tbl_len   (tbl_len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_idx   (err_idx),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  typedef struct {
    logic [5:0]  addr;
    logic [23:0] data;
    logic [1:0]  len;
    int          bits;
    logic [31:0] frame;
  } vec_t;

  typedef struct {
    int          bits;
    logic [31:0] data;
    logic [6:0]  cs;
    int          low;
  } frame_t;

  vec_t        v [6];
  logic [5:0]  t_addr [6];
  logic [23:0] t_data [6];
  logic [1:0]  t_len  [6];
  frame_t      frames [$];
  int          idx_hist [$];
  int          checks = 0;
  int          errors = 0;
  int          rise_total = 0;
  int          done_total = 0;

  // Combinational register table addressed by tbl_idx.
  always_comb begin
    tbl_addr = '0;
    tbl_data = '0;
    tbl_len  = '0;
    if (int'(tbl_idx) < 6) begin
      tbl_addr = t_addr[int'(tbl_idx)];
      tbl_data = t_data[int'(tbl_idx)];
      tbl_len  = t_len[int'(tbl_idx)];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor and AD7124 slave model: captures frames, echoes written
  // registers on readback, except FILTER_0 which returns 0x09E1.
  initial begin : monitor
    logic        sclk_p, in_fr, rd_mode;
    logic [2:0]  idx_p;
    int          fr_bits, fr_low;
    logic [31:0] fr_data, resp;
    logic [6:0]  fr_cs;
    logic [7:0]  cmd;
    logic [31:0] mem [64];
    sclk_p = 1'b1; in_fr = 1'b0; rd_mode = 1'b0; idx_p = 3'd0;
    fr_bits = 0; fr_low = 0; fr_data = '0; resp = '0; fr_cs = '1;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    forever begin
      @(negedge PL_clk);
      if (done === 1'b1) done_total++;
      if (tbl_idx !== idx_p) idx_hist.push_back(int'(tbl_idx));
      idx_p = tbl_idx;
      if (spi_sclk && !sclk_p) begin
        rise_total++;
        if (in_fr) begin
          fr_data = {fr_data[30:0], spi_mosi};
          fr_bits++;
          if (fr_bits == 8 && fr_data[7:6] == 2'b01) begin
            rd_mode = 1'b1;
            resp = (fr_data[5:0] == 6'h21) ? 32'h09E1_0000 : mem[fr_data[5:0]];
          end
        end
      end
      if (!spi_sclk && sclk_p) begin
        if (rd_mode && fr_bits >= 8) begin
          spi_miso = resp[31];
          resp = resp << 1;
        end else begin
          spi_miso = 1'b0;
        end
      end
      if (!(&spi_cs_n)) begin
        if (!in_fr) begin
          in_fr = 1'b1; fr_bits = 0; fr_data = '0; fr_cs = spi_cs_n; fr_low = 0; rd_mode = 1'b0;
        end
        fr_low++;
      end else if (in_fr) begin
        in_fr = 1'b0; rd_mode = 1'b0; spi_miso = 1'b0;
        if (fr_bits > 8) begin
          cmd = 8'(fr_data >> (fr_bits - 8));
          if (cmd[7:6] == 2'b00) mem[cmd[5:0]] = fr_data << (40 - fr_bits);
        end
        frames.push_back('{fr_bits, fr_data, fr_cs, fr_low});
      end
      sclk_p = spi_sclk;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge PL_clk);
  endtask

  task automatic pulse_start(input logic [2:0] cs, input logic ver);
    @(negedge PL_clk);
    chip_sel  = cs;
    verify_en = ver;
    start     = 1'b1;
    @(negedge PL_clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 8000) begin
      @(negedge PL_clk);
      n++;
    end
    check(name, 32'(done), 32'd1);
    tick(3);
  endtask

  task automatic load_table(input int term_at);
    for (int i = 0; i < 6; i++) begin
      t_addr[i] = v[i].addr;
      t_data[i] = v[i].data;
      t_len[i]  = (i == term_at) ? 2'd0 : v[i].len;
    end
  endtask

  initial begin : test
    int b, d0, ib, r0, n;
    v[0] = '{6'h01, 24'h000083, 2'd2, 24, 32'h0001_0083};
    v[1] = '{6'h19, 24'h123456, 2'd3, 32, 32'h1912_3456};
    v[2] = '{6'h03, 24'hEE0A5C, 2'd2, 24, 32'h0003_0A5C};
    v[3] = '{6'h21, 24'h000180, 2'd2, 24, 32'h0021_0180};
    v[4] = '{6'h09, 24'hABCDEF, 2'd3, 32, 32'h09AB_CDEF};
    v[5] = '{6'h2A, 24'h0055AA, 2'd2, 24, 32'h002A_55AA};
    load_table(1);

    // Reset state
    tick(3);
    check("rst_sclk", 32'(spi_sclk), 32'd1);
    check("rst_cs_n", 32'(spi_cs_n), 32'h7F);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_idx", 32'(err_idx), 32'd0);
    check("rst_tbl_idx", 32'(tbl_idx), 32'd0);
    rst = 1'b0;
    tick(3);

    // Single 16-bit write, terminated by a zero-length entry
    b = frames.size(); d0 = done_total;
    pulse_start(3'd0, 1'b0);
    check("t1_busy_rise", 32'(busy), 32'd1);
    wait_done("t1_done_seen");
    check("t1_nframes", 32'(frames.size() - b), 32'd1);
    check("t1_bits", 32'(frames[b].bits), 32'd24);
    check("t1_data", frames[b].data, 32'h0001_0083);
    check("t1_cs", 32'(frames[b].cs), 32'h7E);
    check("t1_cs_low_cycles", 32'(frames[b].low), 32'd100);
    check("t1_done_pulses", 32'(done_total - d0), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_idx_end", 32'(tbl_idx), 32'd0);

    // Mixed-length full table
    load_table(-1);
    b = frames.size(); ib = idx_hist.size();
    pulse_start(3'd0, 1'b0);
    wait_done("t2_done_seen");
    check("t2_nframes", 32'(frames.size() - b), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_bits%0d", i), 32'(frames[b+i].bits), 32'(v[i].bits));
      check($sformatf("t2_data%0d", i), frames[b+i].data, v[i].frame);
    end
    check("t2_idx_changes", 32'(idx_hist.size() - ib), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t2_idx_seq%0d", i), 32'(idx_hist[ib+i]), 32'((i + 1) % 6));

    // Verify with one mismatching readback at entry 3
    b = frames.size();
    pulse_start(3'd0, 1'b1);
    wait_done("t3_done_seen");
    check("t3_nframes", 32'(frames.size() - b), 32'd12);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_wr%0d", i), frames[b+2*i].data, v[i].frame);
      check($sformatf("t3_rd%0d", i), frames[b+2*i+1].data,
            32'({2'b01, v[i].addr}) << (v[i].bits - 8));
    end
    check("t3_err", 32'(err), 32'd1);
    check("t3_err_idx", 32'(err_idx), 32'd3);

    // Early termination; err cleared by the accepted start
    load_table(2);
    b = frames.size(); d0 = done_total;
    pulse_start(3'd0, 1'b0);
    check("t4_err_cleared", 32'(err), 32'd0);
    check("t4_err_idx_cleared", 32'(err_idx), 32'd0);
    wait_done("t4_done_seen");
    check("t4_nframes", 32'(frames.size() - b), 32'd2);
    check("t4_data0", frames[b].data, v[0].frame);
    check("t4_data1", frames[b+1].data, v[1].frame);
    check("t4_done_pulses", 32'(done_total - d0), 32'd1);

    // chip_sel=5 routing; a start during the 2nd frame is ignored
    b = frames.size(); d0 = done_total;
    pulse_start(3'd5, 1'b0);
    n = 0;
    while (!(frames.size() == b + 1 && !(&spi_cs_n)) && n < 4000) begin
      @(negedge PL_clk);
      n++;
    end
    check("t5_second_frame_seen", 32'(n < 4000), 32'd1);
    pulse_start(3'd0, 1'b1);
    wait_done("t5_done_seen");
    tick(60);
    check("t5_nframes", 32'(frames.size() - b), 32'd2);
    check("t5_cs0", 32'(frames[b].cs), 32'h5F);
    check("t5_cs1", 32'(frames[b+1].cs), 32'h5F);
    check("t5_wr_only", frames[b+1].data, v[1].frame);
    check("t5_done_pulses", 32'(done_total - d0), 32'd1);
    check("t5_busy_after", 32'(busy), 32'd0);

    // chip_sel=7: sequence runs with no chip select asserted
    b = frames.size(); d0 = done_total; r0 = rise_total;
    pulse_start(3'd7, 1'b0);
    wait_done("t6_done_seen");
    check("t6_nframes", 32'(frames.size() - b), 32'd0);
    check("t6_sclk_rises", 32'(rise_total - r0), 32'd56);
    check("t6_done_pulses", 32'(done_total - d0), 32'd1);
    check("t6_err", 32'(err), 32'd0);

    // Reset in the middle of a frame, then a clean restart
    load_table(-1);
    r0 = rise_total;
    pulse_start(3'd0, 1'b0);
    n = 0;
    while (rise_total - r0 < 10 && n < 2000) begin
      @(negedge PL_clk);
      n++;
    end
    check("t7_reached_bit10", 32'(n < 2000), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_sclk", 32'(spi_sclk), 32'd1);
    check("t7_rst_cs_n", 32'(spi_cs_n), 32'h7F);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_mosi", 32'(spi_mosi), 32'd0);
    tick(3);
    rst = 1'b0;
    load_table(1);
    tick(3);
    b = frames.size();
    pulse_start(3'd0, 1'b0);
    wait_done("t7_done_seen");
    check("t7_nframes", 32'(frames.size() - b), 32'd1);
    check("t7_bits", 32'(frames[b].bits), 32'd24);
    check("t7_data", frames[b].data, v[0].frame);
    check("t7_cs_low_cycles", 32'(frames[b].low), 32'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
